// File: rtl/instr_loader.sv
// Byte-stream program loader: receives a 16-bit word count then little-endian words and writes them to instruction memory.
// Optional trailer XOR checksum is enabled by defining LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned WCW = $clog2(MEM_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, BYTES, WRITE, CSUM, DONE, ERR
  } state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e TAIL = CSUM;
`else
  localparam state_e TAIL = DONE;
`endif

  state_e           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;
  logic [15:0]      n_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  assign n_full = {rx_data, len_q[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    rx_ready   = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN_LO;
          len_d      = '0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          len_d = n_full;
          if (32'(n_full) > MEM_WORDS)   state_d = ERR;
          else if (n_full == 16'd0)      state_d = TAIL;
          else                           state_d = BYTES;
        end
      end
      BYTES: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          // Shift in from the top so the first byte ends up in bits [7:0]
          word_d = {rx_data, word_q[31:8]};
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = '0;
            state_d    = WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        if ((32'(word_cnt_q) + 32'd1) < 32'(len_q)) begin
          word_cnt_d = word_cnt_q + WCW'(1);
          state_d    = BYTES;
        end else begin
          state_d = TAIL;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = (rx_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = {30'(word_cnt_q), 2'b00};
  assign mem_wdata = word_q;
  assign busy      = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign cpu_rst   = (state_q != DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed and randomized loads against a word-list reference model.
module tb_instr_loader;
  localparam int unsigned MW = 64;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_we, cpu_rst, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  instr_loader #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] wr_q[$];
  int          we_overlap = 0;
  int          we_long = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (mem_we && rx_ready) we_overlap <= we_overlap + 1;
    if (mem_we && prev_we) we_long <= we_long + 1;
    prev_we <= mem_we;
  end

  logic [7:0]  stream[$];
  logic [31:0] exp_w[$];
  bit          exp_err;
  int          exp_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 20 && !acc; t++) begin
      if (rx_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    check("byte_accept", 32'(acc), 32'd1);
  endtask

  // Reference: a load of n words is the word list itself, written to consecutive word addresses.
  task automatic make_case(input logic [15:0] n, input bit bad_csum);
    logic [7:0] x = 8'h00;
    logic [31:0] w;
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    if (32'(n) > MW) begin
      exp_err = 1'b1;
      exp_n   = 0;
    end else begin
      exp_err = CSUM_EN && bad_csum;
      exp_n   = int'(n);
      for (int i = 0; i < exp_n; i++) begin
        w = exp_w[i];
        for (int b = 0; b < 4; b++) begin
          stream.push_back(w[7:0]);
          x ^= w[7:0];
          w = w >> 8;
        end
      end
      if (CSUM_EN) stream.push_back(bad_csum ? (x ^ 8'h01) : x);
    end
  endtask

  task automatic run_case(input int gmin, input int gmax, input bit poke);
    int base = wr_q.size();
    int nw;
    pulse_start();
    for (int j = 0; j < stream.size(); j++) begin
      send_byte(stream[j], $urandom_range(gmax, gmin));
      if (j >= 2 && j < 2 + 4 * exp_n && ((j - 2) % 4) == 3)
        check("we_after_4th", 32'(mem_we), 32'd1);
      if (poke && j == 2) pulse_start();
    end
    repeat (2) @(posedge clk);
    #1;
    nw = wr_q.size() - base;
    check("n_writes", 32'(nw), 32'(exp_n));
    for (int i = 0; i < exp_n && i < nw; i++) begin
      check("wr_addr", wr_q[base + i][63:32], 32'(4 * i));
      check("wr_data", wr_q[base + i][31:0], exp_w[i]);
    end
    check("end_done", 32'(done), 32'(!exp_err));
    check("end_err", 32'(err), 32'(exp_err));
    check("end_cpu_rst", 32'(cpu_rst), 32'(exp_err));
    check("end_busy", 32'(busy), 32'd0);
    check("end_rx_ready", 32'(rx_ready), 32'd0);
    check("we_rx_overlap", 32'(we_overlap), 32'd0);
    check("we_multi_cycle", 32'(we_long), 32'd0);
  endtask

  initial begin
    int base;
    logic [15:0] n;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-word program, back to back then with 3-cycle gaps
    exp_w = {32'hE3A00000, 32'hE2811001};
    make_case(16'd2, 1'b0);
    run_case(0, 0, 1'b0);
    run_case(3, 3, 1'b1);

    // Oversized length is rejected after the length bytes
    exp_w.delete();
    make_case(16'd65, 1'b0);
    run_case(0, 0, 1'b0);
    n = 16'($urandom_range(65535, 66));
    make_case(n, 1'b0);
    run_case(0, 1, 1'b0);

    // Empty program
    exp_w.delete();
    make_case(16'd0, 1'b0);
    run_case(0, 2, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    exp_w = {32'h44332211};
    make_case(16'd1, 1'b0);
    check("csum_trailer_byte", 32'(stream[stream.size() - 1]), 32'h44);
    run_case(0, 0, 1'b0);
    make_case(16'd1, 1'b1);
    run_case(0, 0, 1'b0);
`endif

    // Reset in the middle of the first word
    base = wr_q.size();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_writes", 32'(wr_q.size() - base), 32'd0);
    exp_w = {32'hE3A00000, 32'hE2811001};
    make_case(16'd2, 1'b0);
    run_case(0, 0, 1'b0);

    // Full-depth load reaches the last word address
    exp_w.delete();
    for (int i = 0; i < int'(MW); i++) exp_w.push_back($urandom);
    make_case(16'(MW), 1'b0);
    run_case(0, 0, 1'b0);

    // Randomized loads with random gaps and checksum outcomes
    for (int r = 0; r < 6; r++) begin
      exp_w.delete();
      n = 16'($urandom_range(8, 1));
      for (int i = 0; i < int'(n); i++) exp_w.push_back($urandom);
      make_case(n, 1'($urandom_range(1, 0)));
      run_case(0, 2, r == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
